// File: rtl/jtopl_timer_bank.sv
// OPL-family timer bank: NUM_TIMERS up-counters ticking off the per-sample zero pulse.
// Define JTOPL_TIMER_RDCNT_EN to build the registered counter readback on rd_cnt.
module jtopl_timer_bank #(
    parameter int NUM_TIMERS = 2,
    parameter int CNT_W      = 8,
    parameter int STEP_LOG2  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cenop,
    input  logic                        zero,
    input  logic [NUM_TIMERS*CNT_W-1:0] value,
    input  logic [NUM_TIMERS-1:0]       load,
    input  logic [NUM_TIMERS-1:0]       flagen,
    input  logic [NUM_TIMERS-1:0]       clr_flag,
    output logic [NUM_TIMERS-1:0]       flag,
    output logic [NUM_TIMERS-1:0]       overflow,
    output logic                        irq_n,
    input  logic [2:0]                  rd_sel,
    output logic [CNT_W-1:0]            rd_cnt
);

    localparam int DIV_W = (NUM_TIMERS > 1) ? STEP_LOG2*(NUM_TIMERS-1) : 1;

    logic [DIV_W-1:0]      div_q,    div_d;
    logic [NUM_TIMERS-1:0] load_l_q, load_l_d;
    logic [NUM_TIMERS-1:0] flag_q,   flag_d;
    logic [NUM_TIMERS-1:0] ovf_q,    ovf_d;
    logic                  irq_n_q,  irq_n_d;
    logic [CNT_W-1:0]      cnt_q [NUM_TIMERS];
    logic [CNT_W-1:0]      cnt_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] tick;
    logic [NUM_TIMERS-1:0] ov;

    // Timer i ticks only when the low i*STEP_LOG2 divider bits are all ones.
    always_comb begin
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            tick[i] = cenop & zero;
            for (int unsigned b = 0; b < DIV_W; b++) begin
                if (b < i*STEP_LOG2 && !div_q[b]) tick[i] = 1'b0;
            end
        end
    end

    always_comb begin
        div_d    = div_q;
        load_l_d = load_l_q;
        flag_d   = flag_q;
        ovf_d    = ovf_q;
        irq_n_d  = irq_n_q;
        cnt_d    = cnt_q;
        ov       = '0;
        if (cenop) begin
            if (zero) div_d = div_q + 1'b1;
            load_l_d = load;
            irq_n_d  = ~|flag_q;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (load[i] && !load_l_q[i]) begin
                    cnt_d[i] = value[i*CNT_W +: CNT_W];
                end else if (load[i] && tick[i]) begin
                    if (cnt_q[i] == '1) begin
                        cnt_d[i] = value[i*CNT_W +: CNT_W];
                        ov[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
            ovf_d  = ov;
            // A set in the same cenop as a clear must win.
            flag_d = (flag_q & ~clr_flag) | (ov & flagen);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            load_l_q <= '0;
            flag_q   <= '0;
            ovf_q    <= '0;
            irq_n_q  <= 1'b1;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) cnt_q[i] <= '0;
        end else begin
            div_q    <= div_d;
            load_l_q <= load_l_d;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
            irq_n_q  <= irq_n_d;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign flag     = flag_q;
    assign overflow = ovf_q;
    assign irq_n    = irq_n_q;

`ifdef JTOPL_TIMER_RDCNT_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (cenop) begin
            rd_cnt_d = '0;
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (32'(rd_sel) == i) rd_cnt_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_cnt_q <= '0;
        else        rd_cnt_q <= rd_cnt_d;
    end

    assign rd_cnt = rd_cnt_q;
`else
    logic [2:0] unused_rd_sel;
    assign unused_rd_sel = rd_sel;
    assign rd_cnt        = '0;
`endif

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// Directed bench for jtopl_timer_bank (default parameters); readback checks follow JTOPL_TIMER_RDCNT_EN.
module tb_jtopl_timer_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cenop;
    logic        zero;
    logic [15:0] value;
    logic [1:0]  load;
    logic [1:0]  flagen;
    logic [1:0]  clr_flag;
    logic [1:0]  flag;
    logic [1:0]  overflow;
    logic        irq_n;
    logic [2:0]  rd_sel;
    logic [7:0]  rd_cnt;

    int checks = 0;
    int errors = 0;

    jtopl_timer_bank #(.NUM_TIMERS(2), .CNT_W(8), .STEP_LOG2(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .zero     (zero),
        .value    (value),
        .load     (load),
        .flagen   (flagen),
        .clr_flag (clr_flag),
        .flag     (flag),
        .overflow (overflow),
        .irq_n    (irq_n),
        .rd_sel   (rd_sel),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       cen;
        bit       zr;
        bit [1:0] ld;
        bit [1:0] fe;
        bit [1:0] clr;
        bit [7:0] v0;
        bit [1:0] efl;
        bit [1:0] eov;
        bit       eirq;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cenop = 1'b0; zero = 1'b0; value = '0; load = '0;
        flagen = '0; clr_flag = '0; rd_sel = 3'd0;

        //            cen zr ld     fe     clr    v0     efl    eov    eirq
        tbl[0]  = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[1]  = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[2]  = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[3]  = '{0, 1, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[4]  = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b01, 2'b01, 1};
        tbl[5]  = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b01, 2'b00, 0};
        tbl[6]  = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b01, 2'b00, 0};
        tbl[7]  = '{1, 1, 2'b01, 2'b01, 2'b01, 8'hFE, 2'b01, 2'b01, 0};
        tbl[8]  = '{1, 0, 2'b01, 2'b01, 2'b01, 8'hFE, 2'b00, 2'b00, 0};
        tbl[9]  = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[10] = '{1, 1, 2'b01, 2'b00, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[11] = '{1, 1, 2'b01, 2'b00, 2'b00, 8'hFE, 2'b00, 2'b01, 1};
        tbl[12] = '{1, 0, 2'b01, 2'b00, 2'b00, 8'hFE, 2'b00, 2'b00, 1};
        tbl[13] = '{1, 1, 2'b01, 2'b00, 2'b00, 8'h80, 2'b00, 2'b00, 1};
        tbl[14] = '{1, 1, 2'b01, 2'b01, 2'b00, 8'h80, 2'b01, 2'b01, 1};
        tbl[15] = '{1, 0, 2'b01, 2'b01, 2'b00, 8'h80, 2'b01, 2'b00, 0};
        tbl[16] = '{1, 1, 2'b00, 2'b01, 2'b00, 8'h80, 2'b01, 2'b00, 0};
        tbl[17] = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b00, 0};
        tbl[18] = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b01, 0};
        tbl[19] = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b01, 0};
        tbl[20] = '{1, 0, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b00, 0};
        tbl[21] = '{1, 1, 2'b00, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b00, 0};
        tbl[22] = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b00, 0};
        tbl[23] = '{1, 1, 2'b01, 2'b01, 2'b00, 8'hFF, 2'b01, 2'b01, 0};

        @(negedge clk);
        cyc();
        chk("reset flag", 32'(flag), 32'h0);
        chk("reset overflow", 32'(overflow), 32'h0);
        chk("reset irq_n", 32'(irq_n), 32'h1);
        chk("reset rd_cnt", 32'(rd_cnt), 32'h0);
        rst_n = 1'b1;

        // Timer 0 overflow, masking, set/clear priority, mid-count value change, load hold
        for (int i = 0; i < 24; i++) begin
            cenop    = tbl[i].cen;
            zero     = tbl[i].zr;
            load     = tbl[i].ld;
            flagen   = tbl[i].fe;
            clr_flag = tbl[i].clr;
            value    = {8'h00, tbl[i].v0};
            cyc();
            chk($sformatf("vec%0d flag", i), 32'(flag), 32'(tbl[i].efl));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].eov));
            chk($sformatf("vec%0d irq_n", i), 32'(irq_n), 32'(tbl[i].eirq));
        end

        // Reset mid-count: bring counter 0 to 8'h80 with a flag set, then reset for one clk
        rst_n = 1'b0; cenop = 1'b0; zero = 1'b0; load = '0; clr_flag = '0;
        cyc();
        rst_n = 1'b1; cenop = 1'b1; flagen = 2'b01; value = 16'h00FF; load = 2'b01;
        cyc();
        zero = 1'b1;
        cyc();
        value = 16'h007F;
        cyc();
        cyc();
        zero = 1'b0;
        cyc();
        chk("pre-reset flag", 32'(flag), 32'h1);
        chk("pre-reset irq_n", 32'(irq_n), 32'h0);
        rst_n = 1'b0; cenop = 1'b0; load = '0;
        cyc();
        chk("mid reset flag", 32'(flag), 32'h0);
        chk("mid reset overflow", 32'(overflow), 32'h0);
        chk("mid reset irq_n", 32'(irq_n), 32'h1);
        rst_n = 1'b1; cenop = 1'b1; zero = 1'b0; rd_sel = 3'd0;
        cyc();
        chk("post-reset cnt0 readback", 32'(rd_cnt), 32'h0);

        // Timer 1 at 1/4 rate: value FF overflows only on zeros that see div==3
        flagen = 2'b00; value = 16'hFF00; load = 2'b10;
        cyc();
        for (int k = 0; k < 12; k++) begin
            zero = 1'b1;
            cyc();
            chk($sformatf("t1 zero%0d overflow", k), 32'(overflow), (k % 4 == 3) ? 32'h2 : 32'h0);
            zero = 1'b0;
            cyc();
            chk($sformatf("t1 idle%0d overflow", k), 32'(overflow), 32'h0);
        end
        chk("t1 masked flag", 32'(flag), 32'h0);
        chk("t1 masked irq_n", 32'(irq_n), 32'h1);

        // Counter readback
        load = 2'b00; rd_sel = 3'd0;
        cyc();
        value = 16'h0010; load = 2'b01;
        cyc();
        cyc();
`ifdef JTOPL_TIMER_RDCNT_EN
        chk("rd_cnt after load", 32'(rd_cnt), 32'h10);
`else
        chk("rd_cnt tied after load", 32'(rd_cnt), 32'h0);
`endif
        zero = 1'b1;
        cyc();
        zero = 1'b0;
        cyc();
`ifdef JTOPL_TIMER_RDCNT_EN
        chk("rd_cnt after tick", 32'(rd_cnt), 32'h11);
`else
        chk("rd_cnt tied after tick", 32'(rd_cnt), 32'h0);
`endif
        rd_sel = 3'd5;
        cyc();
        chk("rd_cnt out of range sel", 32'(rd_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
